// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with valid/ready handshake, load-use bubble insertion and branch flush.
// Optional macro WB_FORWARD_EN: forward writeback data into operands at capture and while the slot is held.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [7:0]        id_ctrl,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_pc,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [7:0]        ex_ctrl,
    output logic [CNT_W-1:0]  hazard_cnt
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              load_use_s;
    logic              capture_s;
    logic [DATA_W-1:0] cap_rdata1_s;
    logic [DATA_W-1:0] cap_rdata2_s;
    logic [DATA_W-1:0] hold_rdata1_s;
    logic [DATA_W-1:0] hold_rdata2_s;

    // Hazard detection and input-side handshake; ex_ctrl[5] is MemRead of the instruction in the slot.
    always_comb begin
        load_use_s = ex_valid & ex_ctrl[5] & (ex_rt != REG_ZERO) & id_valid &
                     ((ex_rt == id_rs) | (ex_rt == id_rt));
        id_ready   = rst_n & ~flush & ~load_use_s & (~ex_valid | ex_ready);
        capture_s  = id_valid & id_ready;
    end

`ifdef WB_FORWARD_EN
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic              we,
        input logic [REG_AW-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [REG_AW-1:0] raddr,
        input logic [DATA_W-1:0] rdata
    );
        if (we && (waddr != REG_ZERO) && (waddr == raddr)) begin
            fwd_sel = wdata;
        end else begin
            fwd_sel = rdata;
        end
    endfunction

    // Writeback bypass: read-during-write at capture, and writes landing while the slot is stalled.
    always_comb begin
        cap_rdata1_s  = fwd_sel(wb_we, wb_addr, wb_data, id_rs, id_rdata1);
        cap_rdata2_s  = fwd_sel(wb_we, wb_addr, wb_data, id_rt, id_rdata2);
        hold_rdata1_s = fwd_sel(wb_we, wb_addr, wb_data, ex_rs, ex_rdata1);
        hold_rdata2_s = fwd_sel(wb_we, wb_addr, wb_data, ex_rt, ex_rdata2);
    end
`else
    logic unused_wb_s;

    // Operands pass through untouched; the writeback port is not observed in this build.
    always_comb begin
        cap_rdata1_s  = id_rdata1;
        cap_rdata2_s  = id_rdata2;
        hold_rdata1_s = ex_rdata1;
        hold_rdata2_s = ex_rdata2;
        unused_wb_s   = ^{wb_we, wb_addr, wb_data};
    end
`endif

    // Slot register: flush beats capture, capture beats drain, otherwise hold (with optional bypass).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_pc      <= {DATA_W{1'b0}};
            ex_rs      <= REG_ZERO;
            ex_rt      <= REG_ZERO;
            ex_rd      <= REG_ZERO;
            ex_rdata1  <= {DATA_W{1'b0}};
            ex_rdata2  <= {DATA_W{1'b0}};
            ex_imm     <= {DATA_W{1'b0}};
            ex_ctrl    <= 8'h00;
            hazard_cnt <= {CNT_W{1'b0}};
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (capture_s) begin
            ex_valid  <= 1'b1;
            ex_pc     <= id_pc;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
            ex_rdata1 <= cap_rdata1_s;
            ex_rdata2 <= cap_rdata2_s;
            ex_imm    <= id_imm;
            ex_ctrl   <= id_ctrl;
        end else if (ex_valid && ex_ready) begin
            // A drain while the offer is blocked by load-use is exactly one inserted bubble.
            ex_valid <= 1'b0;
            if (load_use_s && (hazard_cnt != CNT_MAX)) begin
                hazard_cnt <= hazard_cnt + CNT_ONE;
            end else begin
                hazard_cnt <= hazard_cnt;
            end
        end else if (ex_valid) begin
            ex_rdata1 <= hold_rdata1_s;
            ex_rdata2 <= hold_rdata2_s;
        end else begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a random phase, scored against a queue model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [7:0]  id_ctrl;
    logic        flush, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [7:0]  ex_ctrl;
    logic [15:0] hazard_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } slot_t;

    slot_t       sb[$];
    logic [15:0] m_cnt;
    int          n_assert = 0;
    int          n_fail   = 0;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_ctrl(ex_ctrl), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [7:0] ctrl);
        id_valid  = 1'b1;
        id_pc     = pc;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        id_rdata1 = r1;
        id_rdata2 = r2;
        id_imm    = pc ^ 32'h0000_5555;
        id_ctrl   = ctrl;
    endtask

    function automatic logic [31:0] fwd_model(input logic [4:0] ra, input logic [31:0] rd);
        if (FWD && wb_we && (wb_addr != 5'd0) && (wb_addr == ra)) return wb_data;
        return rd;
    endfunction

    // Scoreboard: checks handshake and slot contents mid-cycle, then advances the model to the next edge.
    always @(negedge clk) begin : monitor
        logic  fv, lu, rdy;
        slot_t e;
        if (rst_n) begin
            fv  = (sb.size() != 0);
            lu  = fv && sb[0].ctrl[5] && (sb[0].rt != 5'd0) && id_valid &&
                  ((sb[0].rt == id_rs) || (sb[0].rt == id_rt));
            rdy = !flush && !lu && (!fv || ex_ready);
            check("id_ready", {63'd0, id_ready}, {63'd0, rdy});
            check("ex_valid", {63'd0, ex_valid}, {63'd0, fv});
            check("hazard_cnt", {48'd0, hazard_cnt}, {48'd0, m_cnt});
            if (fv) begin
                e = sb[0];
                check("slot_pc_imm", {ex_pc, ex_imm}, {e.pc, e.imm});
                check("slot_rdata", {ex_rdata1, ex_rdata2}, {e.rdata1, e.rdata2});
                check("slot_regs_ctrl", {41'd0, ex_rs, ex_rt, ex_rd, ex_ctrl},
                      {41'd0, e.rs, e.rt, e.rd, e.ctrl});
                if (!flush && lu && ex_ready && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
                if (!flush && !ex_ready) begin
                    e.rdata1 = fwd_model(e.rs, e.rdata1);
                    e.rdata2 = fwd_model(e.rt, e.rdata2);
                    sb[0] = e;
                end
                if (flush || ex_ready) sb.pop_front();
            end
            if (id_valid && rdy) begin
                e.pc     = id_pc;
                e.imm    = id_imm;
                e.rs     = id_rs;
                e.rt     = id_rt;
                e.rd     = id_rd;
                e.ctrl   = id_ctrl;
                e.rdata1 = fwd_model(id_rs, id_rdata1);
                e.rdata2 = fwd_model(id_rt, id_rdata2);
                sb.push_back(e);
            end
        end
    end

    initial begin
        m_cnt    = 16'd0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        wb_we    = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;
        offer(32'hDEAD, 5'd3, 5'd4, 5'd5, 32'h77, 32'h88, 8'hE0);

        // Reset with an offer pending
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
        check("rst_rdata1", {32'd0, ex_rdata1}, 64'd0);
        check("rst_hazard_cnt", {48'd0, hazard_cnt}, 64'd0);
        check("rst_id_ready", {63'd0, id_ready}, 64'd0);
        rst_n = 1'b1;

        // Pass-through and back-to-back
        offer(32'h100, 5'd3, 5'd4, 5'd2, 32'h52, 32'h11, 8'h80);
        cycle();
        check("pt_valid", {63'd0, ex_valid}, 64'd1);
        check("pt_rdata1", {32'd0, ex_rdata1}, 64'h52);
        for (int i = 0; i < 4; i++) begin
            offer(32'h104 + 32'(4 * i), 5'd1, 5'd2, 5'd3, 32'(i + 1), 32'(i + 9), 8'h81);
            cycle();
            check("b2b_pc", {32'd0, ex_pc}, {32'd0, 32'h104 + 32'(4 * i)});
        end

        // Backpressure for three cycles
        ex_ready = 1'b0;
        offer(32'h200, 5'd8, 5'd9, 5'd1, 32'h1A, 32'h0, 8'h80);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_id_ready", {63'd0, id_ready}, 64'd0);
            cycle();
            check("bp_hold_pc", {32'd0, ex_pc}, 64'h110);
        end
        ex_ready = 1'b1;
        cycle();
        check("bp_taken", {32'd0, ex_rdata1}, 64'h1A);

        // Load-use: lw r5 then add using r5
        offer(32'h300, 5'd1, 5'd5, 5'd5, 32'h0, 32'h0, 8'hE0);
        cycle();
        offer(32'h304, 5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 8'h82);
        #1;
        check("lu_id_ready", {63'd0, id_ready}, 64'd0);
        cycle();
        check("lu_bubble", {63'd0, ex_valid}, 64'd0);
        check("lu_cnt", {48'd0, hazard_cnt}, 64'd1);
        check("lu_ready_after", {63'd0, id_ready}, 64'd1);
        cycle();
        check("lu_capture", {32'd0, ex_pc}, 64'h304);

        // Load-use while execute stalls: no count until it drains
        offer(32'h308, 5'd2, 5'd9, 5'd9, 32'h0, 32'h0, 8'hE0);
        cycle();
        ex_ready = 1'b0;
        offer(32'h30C, 5'd9, 5'd9, 5'd4, 32'h3, 32'h4, 8'h82);
        cycle();
        cycle();
        check("lu_stall_nocount", {48'd0, hazard_cnt}, 64'd1);
        ex_ready = 1'b1;
        cycle();
        check("lu_stall_count", {48'd0, hazard_cnt}, 64'd2);
        cycle();
        check("lu_stall_capture", {32'd0, ex_pc}, 64'h30C);

        // r0 destination of a load never creates a hazard
        offer(32'h400, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 8'hE0);
        cycle();
        offer(32'h404, 5'd0, 5'd0, 5'd1, 32'h5, 32'h6, 8'h80);
        #1;
        check("r0_id_ready", {63'd0, id_ready}, 64'd1);
        cycle();
        check("r0_capture", {32'd0, ex_pc}, 64'h404);

        // Flush of a full, stalled slot with a pending offer
        ex_ready = 1'b0;
        flush    = 1'b1;
        offer(32'h500, 5'd1, 5'd2, 5'd3, 32'h1A, 32'h0, 8'h80);
        #1;
        check("fl_id_ready", {63'd0, id_ready}, 64'd0);
        cycle();
        check("fl_valid", {63'd0, ex_valid}, 64'd0);
        check("fl_cnt", {48'd0, hazard_cnt}, 64'd2);
        flush    = 1'b0;
        ex_ready = 1'b1;
        id_valid = 1'b0;
        cycle();

        // Flush beats hazard counting
        offer(32'h600, 5'd1, 5'd4, 5'd4, 32'h0, 32'h0, 8'hE0);
        cycle();
        offer(32'h604, 5'd4, 5'd1, 5'd2, 32'h0, 32'h0, 8'h80);
        flush = 1'b1;
        cycle();
        check("fl_lu_cnt", {48'd0, hazard_cnt}, 64'd2);
        check("fl_lu_valid", {63'd0, ex_valid}, 64'd0);
        flush    = 1'b0;
        id_valid = 1'b0;
        cycle();

        // Writeback forwarding at capture and while held
        offer(32'h700, 5'd7, 5'd0, 5'd3, 32'hE9, 32'h0, 8'h80);
        wb_we   = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'h69;
        cycle();
        check("fwd_hit", {32'd0, ex_rdata1}, FWD ? 64'h69 : 64'hE9);
        offer(32'h704, 5'd0, 5'd0, 5'd3, 32'hE9, 32'h0, 8'h80);
        wb_addr = 5'd0;
        cycle();
        check("fwd_r0", {32'd0, ex_rdata1}, 64'hE9);
        offer(32'h708, 5'd7, 5'd8, 5'd3, 32'h1, 32'h2, 8'h80);
        wb_we = 1'b0;
        cycle();
        ex_ready = 1'b0;
        id_valid = 1'b0;
        wb_we    = 1'b1;
        wb_addr  = 5'd8;
        wb_data  = 32'h88;
        cycle();
        check("fwd_hold", {32'd0, ex_rdata2}, FWD ? 64'h88 : 64'h2);
        wb_we    = 1'b0;
        ex_ready = 1'b1;
        cycle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            offer($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), $urandom, $urandom, 8'($urandom));
            id_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            wb_we    = $urandom_range(0, 1) == 1;
            wb_addr  = 5'($urandom_range(0, 3));
            wb_data  = $urandom;
            cycle();
        end
        flush = 1'b0;
        wb_we = 1'b0;

        // Asynchronous reset in the middle of a held slot
        ex_ready = 1'b1;
        offer(32'h900, 5'd1, 5'd2, 5'd3, 32'hAB, 32'hCD, 8'h80);
        cycle();
        ex_ready = 1'b0;
        id_valid = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, ex_valid}, 64'd0);
        check("mid_rst_pc", {32'd0, ex_pc}, 64'd0);
        check("mid_rst_cnt", {48'd0, hazard_cnt}, 64'd0);
        sb.delete();
        m_cnt = 16'd0;
        cycle();
        rst_n    = 1'b1;
        ex_ready = 1'b1;
        cycle();
        cycle();
        check("post_rst_valid", {63'd0, ex_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
